pc_fetch_ctrl: RTL and testbench

- Owns the architectural PC and sequences instruction fetch for the IF stage.
- Each accepted fetch advances the PC to PC+4, or to a redirect target that D stage supplies from the next-PC computation (branch/jump/jr).
- Honours MIPS delay-slot semantics: the fetch in flight when a redirect arrives is the delay slot and is kept.
- Talks to a variable-latency instruction memory over a req/ack handshake. Presents an IF/ID register (valid/pc/instr) to D stage, with a one-entry skid buffer to absorb hazard stalls.

---
 rtl/pc_fetch_ctrl_pkg.sv | 28 ++
 rtl/pc_fetch_ctrl_if.sv | 17 +
 rtl/pc_fetch_ctrl_skid_buf.sv | 39 +++
 rtl/pc_fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// ============================================================================
// pc_fetch_ctrl_pkg : shared fetch constants, FSM encoding and IF/ID entry type
// Revision: 1.0
// ============================================================================
`default_nettype none

package pc_fetch_ctrl_pkg;

   localparam logic [31:0] PC_RESET = 32'h0000_3000;

   typedef enum logic [0:0] {
      FETCH_S_FETCH = 1'b0,
      FETCH_S_SKID  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } fetch_entry_t;

   function automatic logic pc_misaligned(input logic [31:0] pc);
      return pc[1:0] != 2'b00;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_fetch_ctrl_if.sv
// ============================================================================
// pc_fetch_ctrl_if : instruction-memory req/ack handshake bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pc_fetch_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

`default_nettype wire

// File: rtl/pc_fetch_ctrl_skid_buf.sv
// ============================================================================
// fetch_skid_buf : one-entry {pc, instr, adel} holding register with valid
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_skid_buf
   import pc_fetch_ctrl_pkg::*;
(
   input  wire logic         clk,
   input  wire logic         reset,
   input  wire logic         load,
   input  wire logic         unload,
   input  wire fetch_entry_t din,
   output fetch_entry_t      dout,
   output logic              valid
);

   fetch_entry_t r_entry;
   logic         r_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_entry <= '0;
         r_valid <= 1'b0;
      end else if (load) begin
         r_entry <= din;
         r_valid <= 1'b1;
      end else if (unload) begin
         r_valid <= 1'b0;
      end
   end

   assign dout  = r_entry;
   assign valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
// pc_fetch_ctrl : architectural PC owner and IF-stage fetch sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = PC_RESET
)(
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic        stall_i,
   input  wire logic        redirect_valid,
   input  wire logic [31:0] redirect_pc,
   pc_fetch_ctrl_if.master  imem,
   output logic             if_valid,
   output logic [31:0]      if_pc,
   output logic [31:0]      if_instr,
   output logic             if_adel
);

   fetch_state_e r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_pend_pc;
   logic         r_pend;
   logic         r_run;
   logic         r_if_valid;
   fetch_entry_t r_if;

   logic         w_misaligned;
   logic         w_fetching;
   logic         w_accept;
   logic         w_redir_now;
   logic         w_unload;
   logic         w_skid_load;
   logic         w_skid_valid;
   fetch_entry_t w_entry;
   fetch_entry_t w_skid_out;

   // r_run holds off the first request until the edge after reset release.
   assign w_misaligned = pc_misaligned(r_pc);
   assign w_fetching   = r_run && (r_state == FETCH_S_FETCH);
   assign w_accept     = w_fetching && (w_misaligned || imem.imem_ack);
   assign w_redir_now  = redirect_valid && !stall_i;
   assign w_unload     = (r_state == FETCH_S_SKID) && !stall_i;
   assign w_skid_load  = w_accept && stall_i && r_if_valid;

   assign w_entry.pc    = r_pc;
   assign w_entry.instr = w_misaligned ? 32'h0 : imem.imem_rdata;
   assign w_entry.adel  = w_misaligned;

   assign imem.imem_req  = w_fetching && !w_misaligned;
   assign imem.imem_addr = r_pc;

   fetch_skid_buf u_skid (
      .clk    (clk),
      .reset  (reset),
      .load   (w_skid_load),
      .unload (w_unload),
      .din    (w_entry),
      .dout   (w_skid_out),
      .valid  (w_skid_valid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= FETCH_S_FETCH;
         r_pc       <= RESET_PC;
         r_pend     <= 1'b0;
         r_pend_pc  <= 32'h0;
         r_run      <= 1'b0;
         r_if_valid <= 1'b0;
         r_if       <= '{pc: RESET_PC, instr: 32'h0, adel: 1'b0};
      end else begin
         r_run <= 1'b1;

         // SKID has no request outstanding, so a redirect there retargets the PC at once.
         if (w_accept) begin
            r_pc   <= r_pend ? r_pend_pc : (w_redir_now ? redirect_pc : r_pc + 32'd4);
            r_pend <= 1'b0;
         end else if (w_unload && w_redir_now) begin
            r_pc   <= redirect_pc;
            r_pend <= 1'b0;
         end else if (w_redir_now) begin
            r_pend    <= 1'b1;
            r_pend_pc <= redirect_pc;
         end

         if (!stall_i) begin
            if (r_state == FETCH_S_SKID) begin
               r_if_valid <= w_skid_valid;
               r_if       <= w_skid_out;
               r_state    <= FETCH_S_FETCH;
            end else if (w_accept) begin
               r_if_valid <= 1'b1;
               r_if       <= w_entry;
            end else begin
               r_if_valid <= 1'b0;
            end
         end else if (w_accept) begin
            if (!r_if_valid) begin
               r_if_valid <= 1'b1;
               r_if       <= w_entry;
            end else begin
               r_state <= FETCH_S_SKID;
            end
         end
      end
   end

   assign if_valid = r_if_valid;
   assign if_pc    = r_if.pc;
   assign if_instr = r_if.instr;
   assign if_adel  = r_if.adel;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// ============================================================================
// tb_pc_fetch_ctrl : directed vector table plus reset / wrap sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch_ctrl;
   import pc_fetch_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redir = 1'b0;
   logic [31:0] rpc = 32'h0;
   logic        ack1 = 1'b0;
   logic        ack2 = 1'b0;

   logic        v1, ad1, v2, ad2;
   logic [31:0] pc1, in1, pc2, in2;

   pc_fetch_ctrl_if bus1();
   pc_fetch_ctrl_if bus2();

   // Memory model: the word at address A is ~A.
   assign bus1.imem_ack   = ack1;
   assign bus1.imem_rdata = ~bus1.imem_addr;
   assign bus2.imem_ack   = ack2;
   assign bus2.imem_rdata = ~bus2.imem_addr;

   pc_fetch_ctrl dut (
      .clk(clk), .reset(reset), .stall_i(stall), .redirect_valid(redir), .redirect_pc(rpc),
      .imem(bus1), .if_valid(v1), .if_pc(pc1), .if_instr(in1), .if_adel(ad1)
   );

   pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .reset(reset), .stall_i(stall), .redirect_valid(redir), .redirect_pc(rpc),
      .imem(bus2), .if_valid(v2), .if_pc(pc2), .if_instr(in2), .if_adel(ad2)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        ack;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic        adel;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs [NV];
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp, input logic a,
                               input logic q, input logic [31:0] ad, input logic v,
                               input logic [31:0] p, input logic e);
      vec_t t;
      t.stall = s; t.redir = r; t.rpc = rp; t.ack = a;
      t.req = q; t.addr = ad; t.valid = v; t.pc = p; t.adel = e;
      return t;
   endfunction

   initial begin
      //               stall redir rpc           ack | req addr          valid pc            adel
      vecs[0]  = mk(0, 0, 32'h0,      0,  0, 32'h0000_3000, 0, 32'h0000_3000, 0);
      vecs[1]  = mk(0, 0, 32'h0,      1,  1, 32'h0000_3000, 0, 32'h0000_3000, 0);
      vecs[2]  = mk(0, 0, 32'h0,      1,  1, 32'h0000_3004, 1, 32'h0000_3000, 0);
      vecs[3]  = mk(0, 0, 32'h0,      1,  1, 32'h0000_3008, 1, 32'h0000_3004, 0);
      vecs[4]  = mk(0, 0, 32'h0,      0,  1, 32'h0000_300C, 1, 32'h0000_3008, 0);
      vecs[5]  = mk(0, 0, 32'h0,      0,  1, 32'h0000_300C, 0, 32'h0,         0);
      vecs[6]  = mk(0, 0, 32'h0,      0,  1, 32'h0000_300C, 0, 32'h0,         0);
      vecs[7]  = mk(1, 0, 32'h0,      1,  1, 32'h0000_300C, 0, 32'h0,         0);
      vecs[8]  = mk(0, 1, 32'h4000,   0,  1, 32'h0000_3010, 1, 32'h0000_300C, 0);
      vecs[9]  = mk(0, 0, 32'h0,      0,  1, 32'h0000_3010, 0, 32'h0,         0);
      vecs[10] = mk(0, 0, 32'h0,      1,  1, 32'h0000_3010, 0, 32'h0,         0);
      vecs[11] = mk(0, 0, 32'h0,      1,  1, 32'h0000_4000, 1, 32'h0000_3010, 0);
      vecs[12] = mk(0, 0, 32'h0,      1,  1, 32'h0000_4004, 1, 32'h0000_4000, 0);
      vecs[13] = mk(1, 0, 32'h0,      1,  1, 32'h0000_4008, 1, 32'h0000_4004, 0);
      vecs[14] = mk(1, 0, 32'h0,      0,  0, 32'h0000_400C, 1, 32'h0000_4004, 0);
      vecs[15] = mk(1, 0, 32'h0,      0,  0, 32'h0000_400C, 1, 32'h0000_4004, 0);
      vecs[16] = mk(0, 0, 32'h0,      0,  0, 32'h0000_400C, 1, 32'h0000_4004, 0);
      vecs[17] = mk(0, 0, 32'h0,      1,  1, 32'h0000_400C, 1, 32'h0000_4008, 0);
      vecs[18] = mk(0, 1, 32'h4002,   1,  1, 32'h0000_4010, 1, 32'h0000_400C, 0);
      vecs[19] = mk(0, 0, 32'h0,      0,  0, 32'h0000_4002, 1, 32'h0000_4010, 0);
      vecs[20] = mk(0, 1, 32'h5000,   0,  0, 32'h0000_4006, 1, 32'h0000_4002, 1);
      vecs[21] = mk(0, 0, 32'h0,      1,  1, 32'h0000_5000, 1, 32'h0000_4006, 1);
      vecs[22] = mk(1, 1, 32'h6000,   0,  1, 32'h0000_5004, 1, 32'h0000_5000, 0);
      vecs[23] = mk(0, 0, 32'h0,      1,  1, 32'h0000_5004, 1, 32'h0000_5000, 0);
      vecs[24] = mk(1, 0, 32'h0,      1,  1, 32'h0000_5008, 1, 32'h0000_5004, 0);
      vecs[25] = mk(0, 1, 32'h7000,   0,  0, 32'h0000_500C, 1, 32'h0000_5004, 0);
      vecs[26] = mk(0, 0, 32'h0,      1,  1, 32'h0000_7000, 1, 32'h0000_5008, 0);
      vecs[27] = mk(0, 0, 32'h0,      0,  1, 32'h0000_7004, 1, 32'h0000_7000, 0);

      repeat (2) @(negedge clk);
      chk("rst.req",    {31'h0, bus1.imem_req}, 32'h0);
      chk("rst.valid",  {31'h0, v1},  32'h0);
      chk("rst.pc",     pc1,          32'h0000_3000);
      chk("rst.instr",  in1,          32'h0);
      chk("rst.adel",   {31'h0, ad1}, 32'h0);
      chk("rst.wrap_pc", pc2,         32'hFFFF_FFFC);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         chk($sformatf("v%0d.req", i),   {31'h0, bus1.imem_req}, {31'h0, vecs[i].req});
         chk($sformatf("v%0d.addr", i),  bus1.imem_addr,         vecs[i].addr);
         chk($sformatf("v%0d.valid", i), {31'h0, v1},            {31'h0, vecs[i].valid});
         if (vecs[i].valid) begin
            chk($sformatf("v%0d.pc", i),    pc1,          vecs[i].pc);
            chk($sformatf("v%0d.instr", i), in1,          vecs[i].adel ? 32'h0 : ~vecs[i].pc);
            chk($sformatf("v%0d.adel", i),  {31'h0, ad1}, {31'h0, vecs[i].adel});
         end
         stall = vecs[i].stall;
         redir = vecs[i].redir;
         rpc   = vecs[i].rpc;
         ack1  = vecs[i].ack;
         @(negedge clk);
      end

      // dut is waiting on 0x7004; reset lands between clock edges.
      chk("wait.req", {31'h0, bus1.imem_req}, 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("arst.req",   {31'h0, bus1.imem_req}, 32'h0);
      chk("arst.valid", {31'h0, v1},            32'h0);
      chk("arst.addr",  bus1.imem_addr,         32'h0000_3000);
      chk("arst.wreq",  {31'h0, bus2.imem_req}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rs.req",   {31'h0, bus1.imem_req}, 32'h1);
      chk("rs.addr",  bus1.imem_addr,         32'h0000_3000);
      chk("rs.valid", {31'h0, v1},            32'h0);
      chk("wr.addr0", bus2.imem_addr,         32'hFFFF_FFFC);
      ack1 = 1'b1;
      ack2 = 1'b1;
      @(negedge clk);
      chk("rs.addr1", bus1.imem_addr, 32'h0000_3004);
      chk("rs.pc0",   pc1,            32'h0000_3000);
      chk("wr.addr1", bus2.imem_addr, 32'h0000_0000);
      chk("wr.pc0",   pc2,            32'hFFFF_FFFC);
      chk("wr.ins0",  in2,            32'h0000_0003);
      @(negedge clk);
      chk("wr.addr2", bus2.imem_addr, 32'h0000_0004);
      chk("wr.pc1",   pc2,            32'h0000_0000);
      chk("wr.valid", {31'h0, v2},    32'h1);
      chk("rs.pc1",   pc1,            32'h0000_3004);
      ack1 = 1'b0;
      ack2 = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
